// File: rtl/spi_flash_slave.sv
// Serial NOR flash emulator behind an oversampled SPI responder (READ/PP/SE/RDSR/WREN/WRDI).
// SPI pins are resynchronised in the sys_clk domain; the byte array is not cleared by reset.
module spi_flash_slave #(
    parameter int MEM_AW    = 8,
    parameter int SECTOR_AW = 4
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic       i_spi_clk,
    input  logic       i_spi_cs,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_busy,
    output logic       o_wel,
    output logic [7:0] o_last_cmd
);
    localparam int SH_W = (MEM_AW > 8) ? MEM_AW : 8;
    localparam logic [MEM_AW-1:0] LO_MASK = MEM_AW'((1 << SECTOR_AW) - 1);
    localparam logic [7:0] OP_WREN = 8'h06, OP_WRDI = 8'h04, OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03, OP_PP = 8'h02, OP_SE = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_STATUS, S_DONE, S_ERASE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_clk_s, r_cs_s;
    logic [1:0]        r_mosi_s;
    logic [SH_W-2:0]   r_shift;
    logic [4:0]        r_cnt;
    logic [7:0]        r_tx, r_last_cmd;
    logic [MEM_AW-1:0] r_addr, r_er_addr;
    logic              r_miso, r_wel, r_busy, r_armed, r_prog_any;
    logic [7:0]        r_mem [2**MEM_AW];

    logic              w_cs, w_rise, w_fall, w_byte_done, w_commit, w_prog_wr;
    logic [SH_W-1:0]   w_sh;
    logic [4:0]        w_bit_last;
    logic [7:0]        w_tx_byte;

    // CS uses the third flop so it lines up with the clock edge pulses: a bit completing a byte wins over a simultaneous CS rise
    assign w_cs        = r_cs_s[2];
    assign w_rise      = r_clk_s[1] & ~r_clk_s[2];
    assign w_fall      = ~r_clk_s[1] & r_clk_s[2];
    assign w_sh        = {r_shift, r_mosi_s[1]};
    assign w_byte_done = w_rise & ~w_cs & (r_cnt == w_bit_last);
    assign w_commit    = w_cs & (r_state != S_IDLE) & (r_state != S_ERASE);
    assign w_prog_wr   = w_byte_done & (r_state == S_PROG) & r_wel;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs) begin
            if (r_state == S_ERASE) begin
                if (!r_busy) w_state_nxt = S_IDLE;
            end else if (r_state != S_IDLE) begin
                w_state_nxt = r_armed ? S_ERASE : S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE, S_ERASE: w_state_nxt = S_CMD;
                S_CMD: if (w_byte_done) begin
                    if (r_busy && (w_sh[7:0] != OP_RDSR)) w_state_nxt = S_DONE;
                    else begin
                        case (w_sh[7:0])
                            OP_RDSR:             w_state_nxt = S_STATUS;
                            OP_READ, OP_PP, OP_SE: w_state_nxt = S_ADDR;
                            default:             w_state_nxt = S_DONE;
                        endcase
                    end
                end
                S_ADDR: if (w_byte_done) begin
                    case (r_last_cmd)
                        OP_READ: w_state_nxt = S_READ;
                        OP_PP:   w_state_nxt = S_PROG;
                        default: w_state_nxt = S_DONE;
                    endcase
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_bit_last = 5'd7;
        w_tx_byte  = r_mem[r_addr];
        if (r_state == S_ADDR)   w_bit_last = 5'd23;
        if (r_state == S_STATUS) w_tx_byte  = {6'b0, r_wel, r_busy};
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            r_clk_s    <= 3'b000;
            r_cs_s     <= 3'b111;
            r_mosi_s   <= 2'b00;
            r_shift    <= '0;
            r_cnt      <= 5'd0;
            r_tx       <= 8'h00;
            r_last_cmd <= 8'h00;
            r_addr     <= '0;
            r_er_addr  <= '0;
            r_miso     <= 1'b0;
            r_wel      <= 1'b0;
            r_busy     <= 1'b0;
            r_armed    <= 1'b0;
            r_prog_any <= 1'b0;
        end else begin
            r_clk_s  <= {r_clk_s[1:0], i_spi_clk};
            r_cs_s   <= {r_cs_s[1:0], i_spi_cs};
            r_mosi_s <= {r_mosi_s[0], i_mosi};
            if (r_busy) begin
                r_er_addr <= r_er_addr + 1'b1;
                if ((r_er_addr & LO_MASK) == LO_MASK) r_busy <= 1'b0;
            end
            if (w_cs) begin
                r_cnt      <= 5'd0;
                r_miso     <= 1'b0;
                r_armed    <= 1'b0;
                r_prog_any <= 1'b0;
                if (w_commit && r_armed) begin
                    r_busy    <= 1'b1;
                    r_wel     <= 1'b0;
                    r_er_addr <= r_addr & ~LO_MASK;
                end
                if (w_commit && (r_state == S_PROG) && r_prog_any) r_wel <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_shift <= w_sh[SH_W-2:0];
                    r_cnt   <= w_byte_done ? 5'd0 : r_cnt + 5'd1;
                end
                if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            r_last_cmd <= w_sh[7:0];
                            if (!r_busy && (w_sh[7:0] == OP_WREN)) r_wel <= 1'b1;
                            if (!r_busy && (w_sh[7:0] == OP_WRDI)) r_wel <= 1'b0;
                        end
                        S_ADDR: begin
                            r_addr <= w_sh[MEM_AW-1:0];
                            if (r_last_cmd == OP_SE) r_armed <= r_wel;
                        end
                        S_PROG: begin
                            r_addr     <= r_addr + 1'b1;
                            r_prog_any <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Byte boundary on a falling edge: present MSB of the next response byte
                if (w_fall && ((r_state == S_READ) || (r_state == S_STATUS))) begin
                    if (r_cnt == 5'd0) begin
                        r_miso <= w_tx_byte[7];
                        r_tx   <= {w_tx_byte[6:0], 1'b0};
                        if (r_state == S_READ) r_addr <= r_addr + 1'b1;
                    end else begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst_n) begin
            if (r_busy)         r_mem[r_er_addr] <= 8'hFF;
            else if (w_prog_wr) r_mem[r_addr]    <= r_mem[r_addr] & w_sh[7:0];
        end
    end

    assign o_miso     = r_miso;
    assign o_busy     = r_busy;
    assign o_wel      = r_wel;
    assign o_last_cmd = r_last_cmd;
endmodule

// File: tb/tb_spi_flash_slave.sv
// Bench for spi_flash_slave: byte-level flash model, directed cases plus random command mix.
module tb_spi_flash_slave;
    localparam int HP = 6;

    logic       clk = 1'b0;
    logic       rst_n, spi_clk, spi_cs, mosi;
    logic       miso, busy, wel;
    logic [7:0] last_cmd;

    always #5 clk = ~clk;

    spi_flash_slave #(.MEM_AW(8), .SECTOR_AW(4)) dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_spi_clk(spi_clk), .i_spi_cs(spi_cs),
        .i_mosi(mosi), .o_miso(miso), .o_busy(busy), .o_wel(wel), .o_last_cmd(last_cmd)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_mem [256];
    logic       m_wel = 1'b0;
    logic [7:0] m_last = 8'h00;
    logic       m_erase = 1'b0;
    logic       mon_en = 1'b0;
    int         quiet = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Between transactions the outputs must match the model on every cycle
    always @(negedge clk) begin
        quiet = spi_cs ? quiet + 1 : 0;
        if (mon_en && quiet > 6) begin
            chk("idle_miso", 32'(miso), 32'd0);
            chk("idle_wel", 32'(wel), 32'(m_wel));
            chk("idle_last_cmd", 32'(last_cmd), 32'(m_last));
        end
    end

    task automatic spi_xfer(input int nbits);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h00;
        rx_q.delete();
        spi_cs = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = tx_q[i / 8];
            mosi = b[7 - (i % 8)];
            repeat (HP) @(negedge clk);
            r = {r[6:0], miso};
            spi_clk = 1'b1;
            repeat (HP) @(negedge clk);
            spi_clk = 1'b0;
            if (i % 8 == 7) rx_q.push_back(r);
        end
        repeat (HP) @(negedge clk);
        spi_cs = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic model_xfer(input int nbits);
        int         nb;
        logic [7:0] op;
        logic [7:0] a;
        nb = nbits / 8;
        exp_q.delete();
        for (int i = 0; i < nb; i++) exp_q.push_back(8'h00);
        m_erase = 1'b0;
        if (nb >= 1) begin
            op = tx_q[0];
            m_last = op;
            a = (nb >= 4) ? tx_q[3] : 8'h00;
            case (op)
                8'h06: m_wel = 1'b1;
                8'h04: m_wel = 1'b0;
                8'h05: for (int i = 1; i < nb; i++) exp_q[i] = {6'b0, m_wel, 1'b0};
                8'h03: for (int i = 4; i < nb; i++) begin
                    exp_q[i] = m_mem[a];
                    a++;
                end
                8'h02: if (nb >= 5) begin
                    for (int i = 4; i < nb; i++) begin
                        if (m_wel) m_mem[a] = m_mem[a] & tx_q[i];
                        a++;
                    end
                    m_wel = 1'b0;
                end
                8'h20: if (nb >= 4 && m_wel) begin
                    for (int i = 0; i < 16; i++) m_mem[{a[7:4], 4'(i)}] = 8'hFF;
                    m_wel = 1'b0;
                    m_erase = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic do_xfer(input int nbits);
        int   blen;
        logic seen;
        mon_en = 1'b0;
        spi_xfer(nbits);
        blen = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                blen++;
            end
        end
        model_xfer(nbits);
        for (int i = 0; i < rx_q.size(); i++)
            chk($sformatf("rx op=%02h byte%0d", tx_q[0], i), 32'(rx_q[i]), 32'(exp_q[i]));
        chk("erase_started", 32'(seen), 32'(m_erase));
        if (m_erase) chk("erase_len_16_to_20", 32'(blen >= 16 && blen <= 20), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        mon_en = 1'b1;
    endtask

    task automatic go();
        do_xfer(8 * tx_q.size());
    endtask

    task automatic op1(input logic [7:0] op, input int extra);
        tx_q.delete();
        tx_q.push_back(op);
        for (int i = 0; i < extra; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic hdr(input logic [7:0] op, input logic [7:0] a, input bit rnd_hi);
        tx_q.delete();
        tx_q.push_back(op);
        tx_q.push_back(rnd_hi ? 8'($urandom) : 8'h00);
        tx_q.push_back(rnd_hi ? 8'($urandom) : 8'h00);
        tx_q.push_back(a);
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic wren();
        op1(8'h06, 0);
        go();
    endtask

    logic [7:0] ops[4] = '{8'h03, 8'h02, 8'h20, 8'h05};

    initial begin
        logic [7:0] a;
        logic [7:0] op;
        int sel;
        rst_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wel", 32'(wel), 32'd0);
        chk("reset_last_cmd", 32'(last_cmd), 32'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int s = 0; s < 16; s++) begin
            wren();
            hdr(8'h20, {4'(s), 4'h0}, 1'b0);
            go();
        end

        wren();
        hdr(8'h20, 8'h10, 1'b0); go();
        chk("se_wel_cleared", 32'(wel), 32'd0);
        hdr(8'h03, 8'h10, 1'b0); pad(16); go();
        for (int i = 4; i < 20; i++) chk("se_read_ff", 32'(rx_q[i]), 32'hFF);

        wren();
        hdr(8'h02, 8'h10, 1'b0); tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); go();
        hdr(8'h03, 8'h10, 1'b0); pad(3); go();
        chk("pp_b0", 32'(rx_q[4]), 32'hA5);
        chk("pp_b1", 32'(rx_q[5]), 32'h3C);
        chk("pp_b2", 32'(rx_q[6]), 32'hFF);
        hdr(8'h02, 8'h10, 1'b0); tx_q.push_back(8'h00); tx_q.push_back(8'h00); go();
        hdr(8'h03, 8'h10, 1'b0); pad(2); go();
        chk("pp_nowel_b0", 32'(rx_q[4]), 32'hA5);
        chk("pp_nowel_b1", 32'(rx_q[5]), 32'h3C);

        wren();
        hdr(8'h02, 8'h10, 1'b0); tx_q.push_back(8'h0F); go();
        hdr(8'h03, 8'h10, 1'b0); pad(1); go();
        chk("pp_and", 32'(rx_q[4]), 32'h05);

        wren();
        hdr(8'h02, 8'h00, 1'b0); tx_q.push_back(8'h12); go();
        wren();
        hdr(8'h02, 8'hFF, 1'b0); tx_q.push_back(8'h34); go();
        hdr(8'h03, 8'hFF, 1'b0); pad(2); go();
        chk("read_wrap_ff", 32'(rx_q[4]), 32'h34);
        chk("read_wrap_00", 32'(rx_q[5]), 32'h12);
        wren();
        hdr(8'h02, 8'hFF, 1'b0); tx_q.push_back(8'hFF); tx_q.push_back(8'hF0); go();
        hdr(8'h03, 8'hFF, 1'b0); pad(2); go();
        chk("pp_wrap_ff", 32'(rx_q[4]), 32'h34);
        chk("pp_wrap_00", 32'(rx_q[5]), 32'h10);

        wren();
        op1(8'h05, 2); go();
        chk("rdsr_wel_b1", 32'(rx_q[1]), 32'h02);
        chk("rdsr_wel_b2", 32'(rx_q[2]), 32'h02);
        op1(8'h04, 0); go();
        op1(8'h05, 1); go();
        chk("rdsr_nowel", 32'(rx_q[1]), 32'h00);

        hdr(8'h20, 8'h10, 1'b0); go();
        hdr(8'h03, 8'h10, 1'b0); pad(1); go();
        chk("se_nowel_kept", 32'(rx_q[4]), 32'h05);

        wren();
        op1(8'h9F, 1); go();
        chk("unknown_miso", 32'(rx_q[1]), 32'h00);
        chk("unknown_wel", 32'(wel), 32'd1);
        chk("unknown_last", 32'(last_cmd), 32'h9F);
        op1(8'h03, 1); do_xfer(12);
        op1(8'h05, 1); go();
        chk("after_partial_rdsr", 32'(rx_q[1]), 32'h02);
        chk("after_partial_last", 32'(last_cmd), 32'h05);

        for (int it = 0; it < 50; it++) begin
            sel = $urandom_range(0, 7);
            a = 8'($urandom);
            case (sel)
                0: begin op1(8'h06, $urandom_range(0, 1)); go(); end
                1: begin op1(8'h04, $urandom_range(0, 1)); go(); end
                2: begin op1(8'h05, $urandom_range(1, 3)); go(); end
                3: begin hdr(8'h03, a, 1'b1); pad($urandom_range(1, 6)); go(); end
                4: begin
                    if ($urandom_range(0, 3) != 0) wren();
                    hdr(8'h02, a, 1'b1); pad($urandom_range(1, 4)); go();
                end
                5: begin
                    if ($urandom_range(0, 1) != 0) wren();
                    hdr(8'h20, a, 1'b1); go();
                end
                6: begin
                    op = 8'($urandom);
                    while (op == 8'h06 || op == 8'h04 || op == 8'h05 ||
                           op == 8'h03 || op == 8'h02 || op == 8'h20) op = 8'($urandom);
                    op1(op, 1); go();
                end
                default: begin
                    if ($urandom_range(0, 1) != 0) wren();
                    hdr(ops[$urandom_range(0, 3)], a, 1'b1); pad(3);
                    do_xfer($urandom_range(1, 55));
                end
            endcase
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
